// File: rtl/mem_burst_slave.sv
// Burst memory slave on a multiplexed address/data bus: page decode, fixed-length
// read/write bursts with in-page address wrap and a latency-matched read return path.
module mem_burst_slave #(
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        PAGE_W    = 4,
  parameter logic [PAGE_W-1:0]  PAGE      = 4'h2,
  parameter int unsigned        BURST_LEN = 4,
  parameter int unsigned        RD_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       resetH,
  input  logic                       AddrValid,
  input  logic                       rw,
  input  logic [DATA_W-1:0]          AddrData_in,
  output logic [DATA_W-1:0]          AddrData_out,
  output logic                       AddrData_oe,
  output logic                       busy,
  output logic [DATA_W-PAGE_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_wrEn,
  output logic                       mem_rdEn,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int unsigned ADDR_W = DATA_W - PAGE_W;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DRAIN
  } state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  base, base_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               hit;
  logic               last_beat;
  logic               last_drain;
  logic               rd_ret;

  assign hit        = (AddrData_in[DATA_W-1:ADDR_W] == PAGE);
  assign last_beat  = (cnt == CNT_W'(BURST_LEN - 1));
  assign last_drain = (cnt == CNT_W'(RD_LAT - 1));

  always_ff @(posedge clk) begin
    if (resetH) begin
      state <= IDLE;
      base  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      base  <= base_nx;
      cnt   <= cnt_nx;
    end
  end

  // cnt counts burst beats in WR/RD and is reused as the drain timer in DRAIN
  always_comb begin
    state_nx = state;
    base_nx  = base;
    cnt_nx   = cnt;
    mem_wrEn = 1'b0;
    mem_rdEn = 1'b0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (AddrValid && hit) begin
          base_nx  = AddrData_in[ADDR_W-1:0];
          cnt_nx   = '0;
          state_nx = rw ? RD : WR;
        end
      end
      WR: begin
        mem_wrEn = 1'b1;
        if (last_beat) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RD: begin
        mem_rdEn = 1'b1;
        if (last_beat) begin
          cnt_nx   = '0;
          state_nx = (RD_LAT == 0) ? IDLE : DRAIN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (last_drain) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sum truncates to ADDR_W bits, so bursts wrap inside the page
  assign mem_addr  = (mem_wrEn || mem_rdEn) ? (base + ADDR_W'(cnt)) : '0;
  assign mem_wdata = mem_wrEn ? AddrData_in : '0;

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign rd_ret = mem_rdEn;
    end else begin : g_pipe
      logic [RD_LAT-1:0] vld;
      always_ff @(posedge clk) begin
        if (resetH) begin
          vld <= '0;
        end else begin
          vld[0] <= mem_rdEn;
          for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld[i] <= vld[i-1];
          end
        end
      end
      assign rd_ret = vld[RD_LAT-1];
    end
  endgenerate

  assign AddrData_oe  = rd_ret;
  assign AddrData_out = rd_ret ? mem_rdata : '0;

endmodule
